// File: rtl/rle_run_packer_if.sv
// Stream-in / token-out bus of the run-length packer.
// The slave modport is the packer's view; master is the producer/consumer side.
interface rle_run_packer_if #(
    parameter int DW = 6,
    parameter int LW = 6
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic [DW-1:0] out_value;
    logic [LW-1:0] out_len;
    logic          out_valid;
    logic          out_ready;
    logic          pat_err;

    modport slave (
        input  in_data, in_valid, flush, out_ready,
        output in_ready, out_value, out_len, out_valid, pat_err
    );

    modport master (
        output in_data, in_valid, flush, out_ready,
        input  in_ready, out_value, out_len, out_valid, pat_err
    );
endinterface

// File: rtl/rle_run_packer.sv
// Collapses a value stream into (value, run length) tokens held in a small FIFO,
// and flags any token that breaks the 1,22,333,... run pattern.
module rle_run_packer #(
    parameter int DW    = 6,
    parameter int LW    = 6,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    rle_run_packer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int MW = (DW > LW) ? DW : LW;
    localparam logic [LW-1:0] RMAX = '1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] run_val, run_val_nxt;
    logic [LW-1:0] run_len, run_len_nxt;
    logic          push;
    logic [DW-1:0] push_val;
    logic [LW-1:0] push_len;

    logic [DW-1:0] mem_val [DEPTH];
    logic [LW-1:0] mem_len [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, accept;
    logic [DW-1:0] exp_val;

    assign full          = (count == (AW+1)'(DEPTH));
    // No pop bypass: a full FIFO stalls input even if the head leaves this cycle.
    assign bus.in_ready  = rst && !bus.flush && !full;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (count != '0);
    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.out_value = mem_val[rd_ptr];
    assign bus.out_len   = mem_len[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            run_val <= '0;
            run_len <= '0;
        end else begin
            state   <= state_nxt;
            run_val <= run_val_nxt;
            run_len <= run_len_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        run_val_nxt = run_val;
        run_len_nxt = run_len;
        push        = 1'b0;
        push_val    = run_val;
        push_len    = run_len;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt   = RUN;
                    run_val_nxt = bus.in_data;
                    run_len_nxt = LW'(1);
                end
            end
            RUN: begin
                if (accept) begin
                    if (bus.in_data == run_val) begin
                        if (run_len == RMAX) begin
                            push        = 1'b1;
                            run_len_nxt = LW'(1);
                        end else begin
                            run_len_nxt = run_len + LW'(1);
                        end
                    end else begin
                        push        = 1'b1;
                        run_val_nxt = bus.in_data;
                        run_len_nxt = LW'(1);
                    end
                end else if (bus.flush && !full) begin
                    push        = 1'b1;
                    state_nxt   = IDLE;
                    run_len_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_val[wr_ptr] <= push_val;
            mem_len[wr_ptr] <= push_len;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Every pushed token, saturated or not, must be (exp, exp).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_val     <= DW'(1);
            bus.pat_err <= 1'b0;
        end else if (push) begin
            if (push_val != exp_val || MW'(push_len) != MW'(push_val))
                bus.pat_err <= 1'b1;
            exp_val <= push_val + DW'(1);
        end
    end
endmodule

// File: tb/tb_rle_run_packer.sv
// Scoreboard bench: directed streams push expected tokens; a negedge monitor
// pops and compares each token the packer hands out.
module tb_rle_run_packer;
    localparam int DW = 6;
    localparam int LW = 6;

    typedef struct packed {
        logic [DW-1:0] val;
        logic [LW-1:0] len;
    } tok_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    tok_t exp_q[$];

    rle_run_packer_if #(.DW(DW), .LW(LW)) bus ();

    rle_run_packer #(.DW(DW), .LW(LW), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_tok(input int v, input int l);
        tok_t t;
        t.val = DW'(v);
        t.len = LW'(l);
        exp_q.push_back(t);
    endtask

    // Hold the beat until the packer takes it; returns at edge+1.
    task automatic send(input int v);
        bit ok = 1'b0;
        bus.in_data  = DW'(v);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && !bus.out_valid) break;
            @(posedge clk);
            #1;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        tok_t t;
        forever begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_token: got (%0d,%0d), expected none",
                             bus.out_value, bus.out_len);
                end else begin
                    t = exp_q.pop_front();
                    if (bus.out_value != t.val || bus.out_len != t.len) begin
                        n_fail++;
                        $display("FAIL token: got (%0d,%0d), expected (%0d,%0d)",
                                 bus.out_value, bus.out_len, t.val, t.len);
                    end
                end
            end
        end
    end

    initial begin
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_pat_err", bus.pat_err, 0);
        rst = 1'b1;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);

        // 1,22,333 then flush
        expect_tok(1, 1); expect_tok(2, 2); expect_tok(3, 3);
        send(1); send(2); send(2); send(3); send(3); send(3);
        do_flush();
        drain("drain_pattern_ok");
        check("pat_ok", bus.pat_err, 0);

        // 1,222: bad run length on the flushed token
        do_reset();
        expect_tok(1, 1); expect_tok(2, 3);
        send(1); send(2); send(2); send(2);
        bus.in_valid = 1'b0;
        check("pat_before_flush", bus.pat_err, 0);
        do_flush();
        check("pat_after_flush", bus.pat_err, 1);
        drain("drain_bad_len");

        // Backpressure: FIFO fills after 5 beats
        do_reset();
        bus.out_ready = 1'b0;
        expect_tok(1, 1); expect_tok(2, 1); expect_tok(3, 1);
        expect_tok(4, 1); expect_tok(5, 1); expect_tok(6, 1);
        for (int v = 1; v <= 5; v++) send(v);
        bus.in_data = DW'(6);
        check("full_in_ready", bus.in_ready, 0);
        check("full_out_valid", bus.out_valid, 1);
        @(posedge clk);
        #1;
        check("full_hold_in_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        send(6);
        do_flush();
        drain("drain_backpressure");
        check("pat_backpressure", bus.pat_err, 1);

        // 70 beats of 5 saturate at RMAX
        do_reset();
        expect_tok(5, 63); expect_tok(5, 7);
        for (int i = 0; i < 70; i++) send(5);
        do_flush();
        drain("drain_saturate");
        check("pat_saturate", bus.pat_err, 1);

        // Async reset with queued tokens
        do_reset();
        bus.out_ready = 1'b0;
        send(1); send(2); send(3); send(4);
        bus.in_valid = 1'b0;
        check("queued_out_valid", bus.out_valid, 1);
        check("queued_pat_err", bus.pat_err, 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_out_valid", bus.out_valid, 0);
        check("async_pat_err", bus.pat_err, 0);
        check("async_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        expect_tok(1, 1);
        send(1);
        do_flush();
        drain("drain_after_reset");
        check("pat_after_reset", bus.pat_err, 0);

        // Flush with nothing open
        do_reset();
        do_flush();
        repeat (3) @(posedge clk);
        #1;
        check("idle_flush_out_valid", bus.out_valid, 0);
        drain("drain_idle_flush");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
